// File: rtl/raster_frame_sequencer.sv
// rtl/raster_frame_sequencer.sv - raster x/y scanner with frame-synchronised game-tick update handshake
// Optional feature macro MISS_COUNT_EN adds a saturating missed_ticks counter output.
module raster_frame_sequencer #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int TICK_DIV = 840000,
  parameter int DIVW     = 20,
  parameter int SPW      = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [SPW-1:0] speed,
  input  logic           update_done,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           pix_valid,
  output logic           frame_start,
  output logic           frame_end,
  output logic           update_req,
  output logic           tick_pending
`ifdef MISS_COUNT_EN
  ,
  output logic [7:0]     missed_ticks
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_UPDATE = 2'd2} state_e;

  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [31:0]   TICK_BASE = 32'(TICK_DIV);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [DIVW-1:0] cnt_q, cnt_d, reload;
  logic            pending_q, pending_d;
  logic [31:0]     shifted;
  logic            tick, hs_done;

  // Period is clamped to one cycle once the shift empties the base count.
  always_comb begin
    shifted = TICK_BASE >> speed;
    reload  = (shifted == 32'd0) ? '0 : DIVW'(shifted - 32'd1);
  end

  assign tick      = (cnt_q == '0);
  assign cnt_d     = tick ? reload : cnt_q - DIVW'(1);
  assign hs_done   = (state_q == S_UPDATE) && update_done;
  assign pending_d = tick | (pending_q & ~hs_done);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    update_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SCAN;
      end
      S_SCAN: begin
        pix_valid   = 1'b1;
        frame_start = (x_q == '0) && (y_q == '0);
        frame_end   = (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d = '0;
            // A pending tick takes precedence over stopping; enable is only looked at here.
            if (pending_q) state_d = S_UPDATE;
            else if (!enable) state_d = S_IDLE;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_UPDATE: begin
        update_req = 1'b1;
        if (update_done) state_d = enable ? S_SCAN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
      cnt_q     <= reload;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign tick_pending = pending_q;

`ifdef MISS_COUNT_EN
  logic [7:0] missed_q, missed_d;

  // A tick merged into an already-pending one is lost unless that same cycle completes the handshake.
  always_comb begin
    missed_d = missed_q;
    if (tick && pending_q && !hs_done && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) missed_q <= '0;
    else       missed_q <= missed_d;
  end

  assign missed_ticks = missed_q;
`endif

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// tb/tb_raster_frame_sequencer.sv - randomized self-checking bench for raster_frame_sequencer
// Reference model tracks a linear pixel index and an absolute tick schedule.
module tb_raster_frame_sequencer;
  localparam int W = 4, H = 3, TD = 16, XW = 2, YW = 2, DIVW = 5, SPW = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1, enable = 1'b0, update_done = 1'b0;
  logic [SPW-1:0] speed = '0;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic           pix_valid, frame_start, frame_end, update_req, tick_pending;
`ifdef MISS_COUNT_EN
  logic [7:0]     missed_ticks;
`endif

  int n_chk = 0, n_pass = 0;
  int m_cyc = 0, m_next_tick = 0, m_pix = 0, m_missed = 0;
  bit m_scan = 0, m_upd = 0, m_pending = 0;

  raster_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .TICK_DIV(TD), .DIVW(DIVW), .SPW(SPW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .update_done(update_done),
    .x(x), .y(y), .pix_valid(pix_valid), .frame_start(frame_start), .frame_end(frame_end),
    .update_req(update_req), .tick_pending(tick_pending)
`ifdef MISS_COUNT_EN
    , .missed_ticks(missed_ticks)
`endif
  );

  function automatic int period(int s);
    int p;
    p = TD >> s;
    return (p < 1) ? 1 : p;
  endfunction

  // One clock edge of the reference, using the inputs as they stood at the edge.
  task automatic model_edge();
    bit tick, hs;
    if (reset) begin
      m_cyc++;
      m_next_tick = m_cyc + period(int'(speed)) - 1;
      m_scan = 0; m_upd = 0; m_pix = 0; m_pending = 0; m_missed = 0;
    end else begin
      tick = (m_cyc == m_next_tick);
      if (tick) m_next_tick = m_cyc + period(int'(speed));
      m_cyc++;
      hs = m_upd && update_done;
      if (tick && m_pending && !hs && m_missed < 255) m_missed++;
      if (m_scan) begin
        if (m_pix == N - 1) begin
          m_pix = 0;
          if (m_pending) begin m_scan = 0; m_upd = 1; end
          else if (!enable) m_scan = 0;
        end else begin
          m_pix++;
        end
      end else if (m_upd) begin
        if (update_done) begin m_upd = 0; m_scan = enable; end
      end else if (enable) begin
        m_scan = 1;
      end
      m_pending = tick || (m_pending && !hs);
    end
  endtask

  function automatic logic [16:0] exp_vec();
    logic [7:0] mm;
`ifdef MISS_COUNT_EN
    mm = 8'(m_missed);
`else
    mm = 8'h00;
`endif
    return {mm, XW'(m_pix % W), YW'(m_pix / W), m_scan, m_scan && (m_pix == 0),
            m_scan && (m_pix == N - 1), m_upd, m_pending};
  endfunction

  function automatic logic [16:0] obs_vec();
    logic [7:0] mm;
`ifdef MISS_COUNT_EN
    mm = missed_ticks;
`else
    mm = 8'h00;
`endif
    return {mm, x, y, pix_valid, frame_start, frame_end, update_req, tick_pending};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int spd);
    reset = 1'b1; enable = 1'b0; update_done = 1'b0; speed = SPW'(spd);
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; speed = '0; update_done = 1'b0;
    repeat (2) begin
      step();
      n_chk++;
      if (obs_vec() !== 17'd0) $display("FAIL reset_state obs=%h exp=%h", obs_vec(), 17'd0);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_frame();
    int fs[$];
    int fe[$];
    logic [3:0] fe_xy;
    logic [9:0] xs;
    bit req_seen;
    fe_xy = '1; xs = '1; req_seen = 0;
    do_reset(0);
    enable = 1'b1;
    for (int c = 0; c < 24; c++) begin
      step();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL frame_cycle c=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
      if (c < 5) xs = {xs[7:0], x};
      if (frame_start) fs.push_back(c);
      if (frame_end && fe.size() == 0) begin fe.push_back(c); fe_xy = {x, y}; end
      if (update_req) req_seen = 1;
    end
    n_chk++;
    if (xs !== 10'h06C) $display("FAIL x_sequence obs=%h exp=%h", xs, 10'h06C); else n_pass++;
    n_chk++;
    if (fe_xy !== 4'hE) $display("FAIL frame_end_xy obs=%h exp=%h", fe_xy, 4'hE); else n_pass++;
    n_chk++;
    if ((fs.size() > 0 && fe.size() > 0 ? fe[0] - fs[0] : -1) != 11)
      $display("FAIL frame_end_offset obs=%0d exp=11", (fs.size() > 0 && fe.size() > 0) ? fe[0] - fs[0] : -1);
    else n_pass++;
    n_chk++;
    if ((fs.size() > 1 ? fs[1] - fs[0] : -1) != 12)
      $display("FAIL back_to_back_frames obs=%0d exp=12", fs.size() > 1 ? fs[1] - fs[0] : -1);
    else n_pass++;
    n_chk++;
    if (req_seen) $display("FAIL no_tick_no_req obs=1 exp=0"); else n_pass++;
  endtask

  task automatic test_update_handshake();
    int waited, req_cycles;
    bit pv_seen;
    waited = 0;
    do_reset(0);
    enable = 1'b1;
    while (!update_req && waited < 60) begin
      step();
      waited++;
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL hs_wait obs=%h exp=%h", obs_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (!update_req) $display("FAIL hs_req_timeout obs=0 exp=1"); else n_pass++;
    req_cycles = update_req ? 1 : 0;
    pv_seen = pix_valid;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) update_done = 1'b1;
      step();
      if (i < 2) begin req_cycles += int'(update_req); pv_seen |= pix_valid; end
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL hs_cycle i=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    update_done = 1'b0;
    n_chk++;
    if (req_cycles != 3) $display("FAIL hs_req_length obs=%0d exp=3", req_cycles); else n_pass++;
    n_chk++;
    if (pv_seen) $display("FAIL hs_pix_valid obs=1 exp=0"); else n_pass++;
    n_chk++;
    if ({update_req, tick_pending, frame_start, pix_valid} !== 4'b0011)
      $display("FAIL hs_release obs=%b exp=%b", {update_req, tick_pending, frame_start, pix_valid}, 4'b0011);
    else n_pass++;
  endtask

  task automatic test_speed_missed();
    int first_pend;
    first_pend = -1;
    do_reset(2);
    enable = 1'b1;
    for (int c = 0; c < 150; c++) begin
      update_done = ($urandom_range(0, 3) == 0);
      step();
      if (tick_pending && first_pend < 0) first_pend = c;
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL speed_cycle c=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    update_done = 1'b0;
    n_chk++;
    if (first_pend != 3) $display("FAIL speed2_first_tick obs=%0d exp=3", first_pend); else n_pass++;
`ifdef MISS_COUNT_EN
    n_chk++;
    if (missed_ticks == 8'd0) $display("FAIL missed_nonzero obs=0 exp=nonzero"); else n_pass++;
`endif
  endtask

  task automatic test_enable_drop();
    bit seen;
    logic [3:0] fe_xy;
    seen = 0; fe_xy = '1;
    do_reset(0);
    enable = 1'b1;
    repeat (2) step();
    n_chk++;
    if ({x, y, pix_valid} !== 5'b01_00_1) $display("FAIL drop_point obs=%b exp=%b", {x, y, pix_valid}, 5'b01001);
    else n_pass++;
    enable = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL drop_cycle obs=%h exp=%h", obs_vec(), exp_vec());
      else n_pass++;
      if (frame_end) begin seen = 1; fe_xy = {x, y}; end
    end
    n_chk++;
    if (fe_xy !== 4'hE) $display("FAIL drop_frame_end obs=%h exp=%h", fe_xy, 4'hE); else n_pass++;
    repeat (3) begin
      step();
      n_chk++;
      if ({pix_valid, update_req, frame_start} !== 3'b000)
        $display("FAIL drop_idle obs=%b exp=%b", {pix_valid, update_req, frame_start}, 3'b000);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_update();
    int waited;
    waited = 0;
    do_reset(0);
    enable = 1'b1;
    while (!update_req && waited < 60) begin
      step();
      waited++;
    end
    n_chk++;
    if (!update_req) $display("FAIL rst_upd_timeout obs=0 exp=1"); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0; enable = 1'b0;
    n_chk++;
    if (obs_vec() !== 17'd0) $display("FAIL rst_in_update obs=%h exp=%h", obs_vec(), 17'd0); else n_pass++;
    step();
    n_chk++;
    if (obs_vec() !== exp_vec()) $display("FAIL rst_after obs=%h exp=%h", obs_vec(), exp_vec()); else n_pass++;
  endtask

  task automatic test_random();
    do_reset(int'($urandom_range(0, 7)));
    for (int c = 0; c < 600; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      update_done = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) speed = SPW'($urandom_range(0, 7));
      step();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_cycle c=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout obs=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_update_handshake();
    test_speed_missed();
    test_enable_drop();
    test_reset_in_update();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
